// File: rtl/sysarr_pkg.sv
// Shared definitions for the systolic-array load/launch sequencing logic.
package sysarr_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CLEAR     = 3'd1,
      ZERO      = 3'd2,
      REWIND    = 3'd3,
      LOAD_W    = 3'd4,
      LOAD_X    = 3'd5,
      START     = 3'd6,
      WAIT_DONE = 3'd7
   } sched_state_e;

endpackage

// File: rtl/phase_counter.sv
// Per-phase element counter: clear wins over increment, last flags depth_p-1.
module phase_counter #(
   parameter int depth_p = 128
) (
   input  logic                       clk_i,
   input  logic                       reset_ni,
   input  logic                       clear_i,
   input  logic                       inc_i,
   output logic [$clog2(depth_p)-1:0] count_o,
   output logic                       last_o
);

   localparam int cnt_w_lp = $clog2(depth_p);
   localparam logic [cnt_w_lp-1:0] last_lp = cnt_w_lp'(depth_p - 1);

   logic [cnt_w_lp-1:0] r_count;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_count <= '0;
      end else if (clear_i) begin
         r_count <= '0;
      end else if (inc_i) begin
         r_count <= r_count + cnt_w_lp'(1);
      end
   end

   assign count_o = r_count;
   assign last_o  = (r_count == last_lp);

endmodule

// File: rtl/sipo_load_sched.sv
// Fills the W then X operand SIPOs from one byte stream, launches the array
// and waits for its completion pulse.
module sipo_load_sched
   import sysarr_pkg::*;
#(
   parameter int width_p = 8,
   parameter int depth_p = 128
) (
   input  logic                       clk_i,
   input  logic                       reset_ni,
   input  logic                       go_i,
   input  logic                       zero_fill_i,
   input  logic                       abort_i,
   input  logic                       valid_i,
   input  logic [width_p-1:0]         data_i,
   output logic                       ready_o,
   output logic                       w_valid_o,
   output logic [width_p-1:0]         w_data_o,
   output logic                       x_valid_o,
   output logic [width_p-1:0]         x_data_o,
   output logic                       sipo_reset_o,
   output logic                       start_o,
   input  logic                       done_i,
   output logic                       done_o,
   output logic                       busy_o,
   output logic [$clog2(depth_p)-1:0] fill_count_o,
   output sched_state_e               dbg_state_o
);

   // Stream handshake: an element transfers on a rising clk_i edge where
   // valid_i and ready_o are both high; the SIPO captures on that same edge.

   sched_state_e r_state;
   logic         r_zf;
   logic         w_hs;
   logic         w_last;
   logic         w_phase_done;
   logic         w_cnt_clear;
   logic         w_cnt_inc;

   assign w_hs = valid_i & ready_o;

   // Any state change (including abort) restarts the per-phase count.
   always_comb begin
      w_phase_done = 1'b0;
      case (r_state)
         IDLE:              w_phase_done = go_i;
         CLEAR, REWIND:     w_phase_done = 1'b1;
         START:             w_phase_done = 1'b1;
         ZERO:              w_phase_done = w_last;
         LOAD_W, LOAD_X:    w_phase_done = w_hs & w_last;
         WAIT_DONE:         w_phase_done = done_i;
         default:           w_phase_done = 1'b0;
      endcase
   end

   assign w_cnt_clear = abort_i | w_phase_done;
   assign w_cnt_inc   = w_hs | (r_state == ZERO);

   phase_counter #(.depth_p(depth_p)) u_phase_counter (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .clear_i  (w_cnt_clear),
      .inc_i    (w_cnt_inc),
      .count_o  (fill_count_o),
      .last_o   (w_last)
   );

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_state <= IDLE;
         r_zf    <= 1'b0;
      end else if (abort_i) begin
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE: if (go_i) begin
               r_zf    <= zero_fill_i;
               r_state <= CLEAR;
            end
            CLEAR:     r_state <= r_zf ? ZERO : LOAD_W;
            ZERO:      if (w_last) r_state <= REWIND;
            REWIND:    r_state <= LOAD_W;
            LOAD_W:    if (w_hs && w_last) r_state <= LOAD_X;
            LOAD_X:    if (w_hs && w_last) r_state <= START;
            START:     r_state <= WAIT_DONE;
            WAIT_DONE: if (done_i) r_state <= IDLE;
            default:   r_state <= IDLE;
         endcase
      end
   end

   // Abort masks every side-effecting output in the cycle it is seen.
   always_comb begin
      ready_o      = 1'b0;
      w_valid_o    = 1'b0;
      w_data_o     = '0;
      x_valid_o    = 1'b0;
      x_data_o     = '0;
      sipo_reset_o = 1'b0;
      start_o      = 1'b0;
      done_o       = 1'b0;
      case (r_state)
         CLEAR, REWIND: sipo_reset_o = !abort_i;
         ZERO: begin
            w_valid_o = !abort_i;
            x_valid_o = !abort_i;
         end
         LOAD_W: begin
            ready_o   = !abort_i;
            w_valid_o = valid_i & !abort_i;
            w_data_o  = data_i;
         end
         LOAD_X: begin
            ready_o   = !abort_i;
            x_valid_o = valid_i & !abort_i;
            x_data_o  = data_i;
         end
         START:     start_o = !abort_i;
         WAIT_DONE: done_o  = done_i & !abort_i;
         default: ;
      endcase
   end

   assign busy_o      = (r_state != IDLE);
   assign dbg_state_o = r_state;

endmodule

// File: tb/tb_sipo_load_sched.sv
// Randomized bench for sipo_load_sched with a queue-based write-order model.
module tb_sipo_load_sched;
   import sysarr_pkg::*;

   localparam int W     = 8;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH);

   logic          clk_i = 1'b0;
   logic          reset_ni = 1'b0;
   logic          go_i = 1'b0;
   logic          zero_fill_i = 1'b0;
   logic          abort_i = 1'b0;
   logic          valid_i = 1'b0;
   logic [W-1:0]  data_i = '0;
   logic          done_i = 1'b0;
   logic          ready_o, w_valid_o, x_valid_o, sipo_reset_o, start_o, done_o, busy_o;
   logic [W-1:0]  w_data_o, x_data_o;
   logic [CW-1:0] fill_count_o;
   sched_state_e  dbg_state_o;

   sipo_load_sched #(.width_p(W), .depth_p(DEPTH)) dut (
      .clk_i        (clk_i),
      .reset_ni     (reset_ni),
      .go_i         (go_i),
      .zero_fill_i  (zero_fill_i),
      .abort_i      (abort_i),
      .valid_i      (valid_i),
      .data_i       (data_i),
      .ready_o      (ready_o),
      .w_valid_o    (w_valid_o),
      .w_data_o     (w_data_o),
      .x_valid_o    (x_valid_o),
      .x_data_o     (x_data_o),
      .sipo_reset_o (sipo_reset_o),
      .start_o      (start_o),
      .done_i       (done_i),
      .done_o       (done_o),
      .busy_o       (busy_o),
      .fill_count_o (fill_count_o),
      .dbg_state_o  (dbg_state_o)
   );

   // ---------------- clock ----------------
   always #5 clk_i = ~clk_i;

   // ---------------- scoreboard state ----------------
   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int n_srst = 0;
   int n_start = 0;
   int n_done = 0;
   int last_xhs_cyc = -1;
   int start_cyc = -1;
   logic [W-1:0] exp_w_q[$];
   logic [W-1:0] exp_x_q[$];
   logic [W-1:0] obs_w_q[$];
   logic [W-1:0] obs_x_q[$];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
      end
   endtask

   always @(posedge clk_i) cyc++;

   // Passive monitor: record every SIPO write and every control pulse.
   always @(negedge clk_i) begin
      if (reset_ni) begin
         if (w_valid_o) obs_w_q.push_back(w_data_o);
         if (x_valid_o) obs_x_q.push_back(x_data_o);
         if (w_valid_o ^ x_valid_o)
            check_val("load_strobe_needs_handshake", {31'd0, valid_i & ready_o}, 32'd1);
         if (x_valid_o && !w_valid_o) last_xhs_cyc = cyc;
         if (sipo_reset_o) n_srst++;
         if (start_o) begin
            n_start++;
            start_cyc = cyc;
         end
         if (done_o) n_done++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic pulse_go(input bit zf);
      go_i = 1'b1;
      zero_fill_i = zf;
      tick();
      go_i = 1'b0;
      zero_fill_i = 1'b0;
   endtask

   task automatic stream(input logic [W-1:0] stim[2*DEPTH], input int n,
                         input bit bubbles, input bit poke);
      int idx = 0;
      int budget = 0;
      bit hs;
      bit done_poked = 1'b0;
      while (idx < n && budget < 500) begin
         valid_i = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
         data_i  = stim[idx];
         go_i    = poke && idx == 1;
         zero_fill_i = poke && idx == 1;
         done_i  = poke && idx == DEPTH + 1 && !done_poked;
         if (done_i) done_poked = 1'b1;
         @(negedge clk_i);
         hs = valid_i && ready_o;
         if (ready_o) check_val("fill_count", 32'(fill_count_o), 32'(idx % DEPTH));
         tick();
         if (hs) idx++;
         budget++;
      end
      valid_i = 1'b0;
      go_i = 1'b0;
      zero_fill_i = 1'b0;
      done_i = 1'b0;
      check_val("stream_accepted", 32'(idx), 32'(n));
   endtask

   task automatic gen_stim(output logic [W-1:0] stim[2*DEPTH]);
      for (int i = 0; i < 2 * DEPTH; i++) stim[i] = W'($urandom_range(0, 255));
   endtask

   task automatic compare_queues();
      check_val("w_write_count", 32'(obs_w_q.size()), 32'(exp_w_q.size()));
      check_val("x_write_count", 32'(obs_x_q.size()), 32'(exp_x_q.size()));
      while (obs_w_q.size() > 0 && exp_w_q.size() > 0)
         check_val("w_data", 32'(obs_w_q.pop_front()), 32'(exp_w_q.pop_front()));
      while (obs_x_q.size() > 0 && exp_x_q.size() > 0)
         check_val("x_data", 32'(obs_x_q.pop_front()), 32'(exp_x_q.pop_front()));
      obs_w_q.delete(); obs_x_q.delete(); exp_w_q.delete(); exp_x_q.delete();
   endtask

   task automatic run_load(input bit zf, input bit bubbles, input bit poke, input bit abort_done);
      logic [W-1:0] stim[2*DEPTH];
      int srst0 = n_srst;
      int st0 = n_start;
      int dn0 = n_done;
      int waited = 0;
      gen_stim(stim);
      for (int i = 0; i < DEPTH; i++) begin
         if (zf) begin
            exp_w_q.push_back('0);
            exp_x_q.push_back('0);
         end
      end
      for (int i = 0; i < DEPTH; i++) exp_w_q.push_back(stim[i]);
      for (int i = 0; i < DEPTH; i++) exp_x_q.push_back(stim[DEPTH + i]);
      pulse_go(zf);
      stream(stim, 2 * DEPTH, bubbles, poke);
      while (n_start == st0 && waited < 20) begin
         tick();
         waited++;
      end
      check_val("start_seen", 32'(n_start - st0), 32'd1);
      check_val("start_latency", 32'(start_cyc - last_xhs_cyc), 32'd1);
      repeat ($urandom_range(0, 3)) tick();
      done_i = 1'b1;
      abort_i = abort_done;
      @(negedge clk_i);
      check_val(abort_done ? "done_under_abort" : "done_pulse", {31'd0, done_o}, {31'd0, !abort_done});
      tick();
      done_i = 1'b0;
      abort_i = 1'b0;
      @(negedge clk_i);
      check_val("busy_after_done", {31'd0, busy_o}, 32'd0);
      check_val("idle_after_done", 32'(dbg_state_o), 32'(IDLE));
      check_val("sipo_reset_pulses", 32'(n_srst - srst0), zf ? 32'd2 : 32'd1);
      check_val("start_pulses", 32'(n_start - st0), 32'd1);
      check_val("done_pulses", 32'(n_done - dn0), abort_done ? 32'd0 : 32'd1);
      compare_queues();
      tick();
   endtask

   task automatic run_abort();
      logic [W-1:0] stim[2*DEPTH];
      int srst0 = n_srst;
      int st0 = n_start;
      gen_stim(stim);
      exp_w_q.push_back(stim[0]);
      exp_w_q.push_back(stim[1]);
      pulse_go(1'b0);
      stream(stim, 2, 1'b0, 1'b0);
      valid_i = 1'b1;
      data_i = stim[2];
      abort_i = 1'b1;
      @(negedge clk_i);
      check_val("abort_ready", {31'd0, ready_o}, 32'd0);
      check_val("abort_w_strobe", {31'd0, w_valid_o}, 32'd0);
      tick();
      abort_i = 1'b0;
      valid_i = 1'b0;
      @(negedge clk_i);
      check_val("abort_state", 32'(dbg_state_o), 32'(IDLE));
      check_val("abort_busy", {31'd0, busy_o}, 32'd0);
      repeat (3) tick();
      check_val("abort_no_start", 32'(n_start - st0), 32'd0);
      check_val("abort_srst", 32'(n_srst - srst0), 32'd1);
      compare_queues();
   endtask

   task automatic run_reset_mid_x();
      logic [W-1:0] stim[2*DEPTH];
      gen_stim(stim);
      for (int i = 0; i < DEPTH; i++) exp_w_q.push_back(stim[i]);
      exp_x_q.push_back(stim[DEPTH]);
      exp_x_q.push_back(stim[DEPTH + 1]);
      pulse_go(1'b0);
      stream(stim, DEPTH + 2, 1'b0, 1'b0);
      valid_i = 1'b1;
      data_i = stim[DEPTH + 2];
      #2 reset_ni = 1'b0;
      #1;
      check_val("rst_outputs",
                {20'd0, ready_o, w_valid_o, x_valid_o, sipo_reset_o, start_o, done_o, busy_o,
                 fill_count_o, 3'd0},
                32'd0);
      check_val("rst_data", {16'd0, w_data_o, x_data_o}, 32'd0);
      valid_i = 1'b0;
      repeat (2) @(negedge clk_i);
      #2 reset_ni = 1'b1;
      compare_queues();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         check_val("busy_after_reset", {31'd0, busy_o}, 32'd0);
      end
      tick();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      repeat (3) @(negedge clk_i);
      check_val("reset_busy", {31'd0, busy_o}, 32'd0);
      check_val("reset_ready", {31'd0, ready_o}, 32'd0);
      check_val("reset_count", 32'(fill_count_o), 32'd0);
      check_val("reset_state", 32'(dbg_state_o), 32'(IDLE));
      reset_ni = 1'b1;
      tick();
      done_i = 1'b1;
      @(negedge clk_i);
      check_val("idle_ignores_done", {31'd0, done_o}, 32'd0);
      tick();
      done_i = 1'b0;

      run_load(1'b0, 1'b0, 1'b0, 1'b0);
      run_load(1'b1, 1'b0, 1'b0, 1'b0);
      run_load(1'b0, 1'b1, 1'b0, 1'b0);
      run_abort();
      run_load(1'b0, 1'b0, 1'b0, 1'b0);
      run_load(1'b0, 1'b1, 1'b1, 1'b0);
      run_load(1'b0, 1'b0, 1'b0, 1'b1);
      run_reset_mid_x();
      for (int i = 0; i < 6; i++)
         run_load(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1);
   end

endmodule

// File: doc/sipo_load_sched.md
Name: sipo_load_sched

Overview:
- Sequencer that fills the two systolic-array operand SIPO buffers (weights W, activations X) from one byte stream, then launches the array and waits for completion.
- Sits between the UART/host byte stream and the W/X SIPO write ports on the icebreaker top level.
- Owns SIPO write-pointer rewinds and optional zero-fill, because a SIPO reset does not clear SIPO contents.

Parameters:
- width_p, 8, element width in bits; must match SIPO width_p.
- depth_p, 128, elements per SIPO; must be at least 2 and match SIPO depth_p.

Ports:
- clk_i  in  1  single clock.
- reset_ni  in  1  asynchronous active-low reset.
- go_i  in  1  start-load pulse; honoured only in IDLE.
- zero_fill_i  in  1  sampled with go_i; 1 selects a zero pass before loading.
- abort_i  in  1  synchronous abort to IDLE from any state.
- valid_i  in  1  stream element valid.
- data_i  in  width_p  stream element.
- ready_o  out  1  stream ready.
- w_valid_o  out  1  W SIPO write strobe.
- w_data_o  out  width_p  W SIPO write data.
- x_valid_o  out  1  X SIPO write strobe.
- x_data_o  out  width_p  X SIPO write data.
- sipo_reset_o  out  1  active-high synchronous pointer reset to both SIPOs.
- start_o  out  1  one-cycle array start.
- done_i  in  1  array completion pulse.
- done_o  out  1  one-cycle completion pulse to host.
- busy_o  out  1  high when state is not IDLE.
- fill_count_o  out  $clog2(depth_p)  elements written in the current phase.

Behaviour:
- Reset (reset_ni=0, async):
  - state=IDLE, counter=0, zf_r=0.
  - All outputs 0 while reset is asserted.
- Output timing:
  - ready_o, write strobes, sipo_reset_o, start_o, done_o and busy_o decode combinationally from the registered state.
  - Write data is combinational.
  - A handshake is valid_i and ready_o in the same cycle. The SIPO captures on that same edge: zero added latency.
- Counter:
  - Width $clog2(depth_p), unsigned.
  - Increments by 1 per accepted write.
  - Cleared on every phase transition.
  - Drives fill_count_o.
- The block never uses SIPO valid_o. Phase end comes from the internal counter only.
- IDLE:
  - ready_o=0.
  - go_i=1: latch zf_r=zero_fill_i, go to CLEAR.
- CLEAR:
  - sipo_reset_o=1 for exactly 1 cycle.
  - Next state is ZERO if zf_r=1, otherwise LOAD_W.
- ZERO:
  - w_valid_o=x_valid_o=1 and w_data_o=x_data_o=0 every cycle; ready_o=0.
  - Counter counts 0..depth_p-1.
  - On the cycle the counter equals depth_p-1, go to REWIND.
- REWIND:
  - sipo_reset_o=1 for 1 cycle, then LOAD_W.
- LOAD_W:
  - ready_o=1, w_valid_o=valid_i, w_data_o=data_i; x_valid_o=0.
  - A handshake when the counter equals depth_p-1 moves to LOAD_X.
  - Bubbles (valid_i=0) stall without side effects.
- LOAD_X:
  - Mirror of LOAD_W on the X port.
  - The final handshake moves to START.
- START:
  - start_o=1 for 1 cycle, ready_o=0, then WAIT_DONE.
- WAIT_DONE:
  - ready_o=0.
  - done_i=1: done_o=1 for that cycle, go to IDLE.
- Ignored inputs:
  - done_i in any state other than WAIT_DONE.
  - go_i outside IDLE.
- Abort:
  - abort_i=1 has top priority in every state.
  - Next state is IDLE; the current cycle's outputs are suppressed (no write strobes, start_o=0, done_o=0).
  - A partial load is discarded; the next go_i re-enters CLEAR.
- Simultaneous abort_i and done_i in WAIT_DONE: abort wins, done_o=0.
- Strobes per load: exactly depth_p writes to W, then exactly depth_p to X, with no write crossing phases. The last W element and the first X element never share a cycle.
- Counter wrap: never reached, because the phase exits at depth_p-1.

Decomposition:
- Shared package sysarr_pkg holds the state enum sched_state_e (IDLE, CLEAR, ZERO, REWIND, LOAD_W, LOAD_X, START, WAIT_DONE).
- One natural sub-module: phase_counter (parameter depth_p; inputs clear, inc; outputs count, last). It is reused by the array-drain logic.
- The W/X output demux stays inline.

Test Plan (bench depth_p=4, width_p=8):
- Reset, then go_i with zero_fill_i=0; stream 0x01..0x08 with valid_i held high:
  - sipo_reset_o pulses 1 cycle.
  - W receives 0x01..0x04, X receives 0x05..0x08.
  - start_o pulses exactly 1 cycle after the 0x08 handshake.
  - done_i yields a done_o pulse and busy_o=0 on the next cycle.
- go_i with zero_fill_i=1:
  - 4 cycles of zero writes to both ports.
  - REWIND asserts sipo_reset_o, then loading proceeds as in the first scenario.
- Stream with bubbles (valid_i toggling 1,0,0,1,...):
  - fill_count_o advances only on handshakes.
  - No strobe is emitted while valid_i=0.
  - The phase change still occurs after the 4th W element.
- abort_i after 2 W elements:
  - Next cycle state is IDLE, ready_o=0, no start_o.
  - A following go_i restarts with a sipo_reset_o pulse and fill_count_o=0.
- Ignored inputs:
  - done_i pulsed during LOAD_X produces no done_o and no state change.
  - go_i during LOAD_W is ignored.
  - abort_i and done_i together in WAIT_DONE give done_o=0 and IDLE.
- Assert reset_ni=0 mid-LOAD_X, asynchronously between clock edges:
  - All outputs drop to 0 immediately.
  - After release, busy_o=0 until go_i.
